// File: rtl/rx_clk_lane.sv
// D-PHY receive clock-lane monitor: tracks LP-11 -> LP-01 -> LP-00 -> HS entry and forwards the HS clock.
// Optional clock-miss timeout in HS_CLK is enabled by defining RX_CLK_LANE_MISS_DETECT_EN.
module rx_clk_lane #(
  parameter int Tclk_term_en = 2,
  parameter int Tclk_miss    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CLKDp,
  input  logic       CLKDn,
  output logic       RX_HS_CLK,
  output logic [2:0] state
);

  if (Tclk_term_en < 1 || Tclk_miss < 1) begin : g_bad_param
    $error("rx_clk_lane: Tclk_term_en and Tclk_miss must be >= 1");
  end

  typedef enum logic [2:0] {
    S_STOP      = 3'd0,
    S_HS_RQST   = 3'd1,
    S_HS_PRPR   = 3'd2,
    S_HS_CLK    = 3'd3,
    S_WAIT_STOP = 3'd4
  } state_t;

  localparam int TW = $clog2(Tclk_term_en) + 1;

  state_t          state_q, state_d;
  logic [TW-1:0]   term_cnt, term_cnt_d, term_inc;
  logic [1:0]      ls;

  assign ls       = {CLKDp, CLKDn};
  assign term_inc = (term_cnt == {TW{1'b1}}) ? term_cnt : term_cnt + 1'b1;
  assign state    = state_q;

`ifdef RX_CLK_LANE_MISS_DETECT_EN
  localparam int MW = $clog2(Tclk_miss) + 1;
  logic [MW-1:0] miss_cnt, miss_cnt_d, miss_inc;
  assign miss_inc = (miss_cnt == {MW{1'b1}}) ? miss_cnt : miss_cnt + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_STOP;
      term_cnt <= '0;
`ifdef RX_CLK_LANE_MISS_DETECT_EN
      miss_cnt <= '0;
`endif
    end else begin
      state_q  <= state_d;
      term_cnt <= term_cnt_d;
`ifdef RX_CLK_LANE_MISS_DETECT_EN
      miss_cnt <= miss_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    term_cnt_d = term_cnt;
`ifdef RX_CLK_LANE_MISS_DETECT_EN
    miss_cnt_d = miss_cnt;
`endif
    case (state_q)
      S_STOP: begin
        if (ls == 2'b01) state_d = S_HS_RQST;
      end
      S_HS_RQST: begin
        case (ls)
          2'b00: begin
            state_d    = S_HS_PRPR;
            term_cnt_d = '0;
          end
          2'b11:   state_d = S_STOP;
          2'b10:   state_d = S_WAIT_STOP;
          default: state_d = S_HS_RQST;
        endcase
      end
      S_HS_PRPR: begin
        // The LP-00 sample that entered prepare counts as the first prepare cycle.
        if (ls == 2'b11) begin
          state_d = S_STOP;
        end else begin
          term_cnt_d = term_inc;
          if (int'(term_inc) >= Tclk_term_en - 1) begin
            state_d = S_HS_CLK;
`ifdef RX_CLK_LANE_MISS_DETECT_EN
            miss_cnt_d = '0;
`endif
          end
        end
      end
      S_HS_CLK: begin
        if (ls == 2'b11) begin
          state_d = S_STOP;
`ifdef RX_CLK_LANE_MISS_DETECT_EN
        end else if (ls == 2'b00) begin
          // Only equal lines count as a miss; complementary lines mean the clock is alive.
          miss_cnt_d = miss_inc;
          if (int'(miss_cnt) >= Tclk_miss - 1) state_d = S_WAIT_STOP;
        end else begin
          miss_cnt_d = '0;
`endif
        end
      end
      S_WAIT_STOP: begin
        if (ls == 2'b11) state_d = S_STOP;
      end
      default: state_d = S_STOP;
    endcase
  end

  // The HS clock can outrun clk, so it is gated straight from the pad, never registered.
  always_comb begin
    RX_HS_CLK = (state_q == S_HS_CLK) && CLKDp;
  end

endmodule

// File: tb/tb_rx_clk_lane.sv
// Self-checking bench for rx_clk_lane: vector table, hand-written corner sequences, random stimulus vs model.
module tb_rx_clk_lane;

  localparam int T_TERM = 2;
  localparam int T_MISS = 4;

  localparam logic [2:0] ST_STOP = 3'd0;
  localparam logic [2:0] ST_RQST = 3'd1;
  localparam logic [2:0] ST_PRPR = 3'd2;
  localparam logic [2:0] ST_HS   = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       CLKDp, CLKDn;
  logic       RX_HS_CLK;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];

  // model: lane phase plus unbounded sample counts
  logic [2:0] m_state;
  int         m_prep;
  int         m_miss;

  rx_clk_lane #(.Tclk_term_en(T_TERM), .Tclk_miss(T_MISS)) dut (
    .clk       (clk),
    .rst       (rst),
    .CLKDp     (CLKDp),
    .CLKDn     (CLKDn),
    .RX_HS_CLK (RX_HS_CLK),
    .state     (state)
  );

  // clock / reset
  always #10 clk = ~clk;

  function automatic void model_reset();
    m_state = ST_STOP;
    m_prep  = 0;
    m_miss  = 0;
  endfunction

  // Prepare: the first LP-00 is prepare sample 1; HS starts once T_TERM prepare samples are seen.
  // HS: T_MISS consecutive LP-00 samples declare a lost clock (when the timeout is built in).
  function automatic void model_step(input logic [1:0] ls);
    if (ls == 2'b11) begin
      model_reset();
    end else if (m_state == ST_STOP) begin
      if (ls == 2'b01) m_state = ST_RQST;
    end else if (m_state == ST_RQST) begin
      if (ls == 2'b00) begin
        m_state = ST_PRPR;
        m_prep  = 1;
      end else if (ls == 2'b10) begin
        m_state = ST_WAIT;
      end
    end else if (m_state == ST_PRPR) begin
      m_prep = m_prep + 1;
      if (m_prep >= T_TERM) begin
        m_state = ST_HS;
        m_miss  = 0;
      end
    end else if (m_state == ST_HS) begin
      if (ls == 2'b00) begin
`ifdef RX_CLK_LANE_MISS_DETECT_EN
        m_miss = m_miss + 1;
        if (m_miss >= T_MISS) m_state = ST_WAIT;
`endif
      end else begin
        m_miss = 0;
      end
    end
  endfunction

  task automatic check_val(input string name, input logic [2:0] act_st, input logic [2:0] exp_st,
                           input logic act_hs, input logic exp_hs);
    checks = checks + 1;
    if (act_st !== exp_st) begin
      errors = errors + 1;
      $display("FAIL %s state: got %0d expected %0d at %0t", name, act_st, exp_st, $time);
    end
    checks = checks + 1;
    if (act_hs !== exp_hs) begin
      errors = errors + 1;
      $display("FAIL %s RX_HS_CLK: got %0b expected %0b at %0t", name, act_hs, exp_hs, $time);
    end
  endtask

  // driver: apply one line state at the falling edge, score it just after the rising edge
  task automatic step(input string name, input logic [1:0] ls);
    logic [2:0] e;
    @(negedge clk);
    {CLKDp, CLKDn} = ls;
    if (rst) model_reset();
    else model_step(ls);
    exp_q.push_back(m_state);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val(name, state, e, RX_HS_CLK, (e == ST_HS) && CLKDp);
  endtask

  typedef struct {
    logic [1:0] ls;
    logic [2:0] st;
    logic       hs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic p;
    vecs = '{
      '{2'b01, ST_RQST, 1'b0}, '{2'b00, ST_PRPR, 1'b0}, '{2'b00, ST_HS,   1'b0},
      '{2'b10, ST_HS,   1'b1}, '{2'b01, ST_HS,   1'b0}, '{2'b10, ST_HS,   1'b1},
      '{2'b00, ST_HS,   1'b0}, '{2'b11, ST_STOP, 1'b0}, '{2'b10, ST_STOP, 1'b0},
      '{2'b01, ST_RQST, 1'b0}, '{2'b01, ST_RQST, 1'b0}, '{2'b11, ST_STOP, 1'b0},
      '{2'b01, ST_RQST, 1'b0}, '{2'b00, ST_PRPR, 1'b0}, '{2'b10, ST_HS,   1'b1},
      '{2'b11, ST_STOP, 1'b0}, '{2'b01, ST_RQST, 1'b0}, '{2'b00, ST_PRPR, 1'b0},
      '{2'b11, ST_STOP, 1'b0}, '{2'b01, ST_RQST, 1'b0}, '{2'b10, ST_WAIT, 1'b0},
      '{2'b01, ST_WAIT, 1'b0}, '{2'b00, ST_WAIT, 1'b0}, '{2'b11, ST_STOP, 1'b0}
    };

    rst = 1'b1;
    {CLKDp, CLKDn} = 2'b11;
    model_reset();
    step("reset0", 2'b11);
    step("reset1", 2'b11);
    rst = 1'b0;
    step("idle", 2'b11);

    // table of hand-derived vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      {CLKDp, CLKDn} = vecs[i].ls;
      model_step(vecs[i].ls);
      @(posedge clk);
      #1;
      check_val($sformatf("vec%0d", i), state, vecs[i].st, RX_HS_CLK, vecs[i].hs);
    end

    // fast complementary burst: toggles stay clear of the clk rising edge
    step("burst_rqst", 2'b01);
    step("burst_prpr", 2'b00);
    step("burst_hs", 2'b00);
    p = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      p = ~p;
      {CLKDp, CLKDn} = {p, ~p};
      #1;
      check_val("burst_mirror", state, ST_HS, RX_HS_CLK, p);
      #4;
    end
    m_miss = 0;
    step("burst_end", 2'b11);

    // long LP-00: clock miss (timeout build) or held HS_CLK
    step("miss_rqst", 2'b01);
    for (int i = 0; i < T_TERM + T_MISS + 1; i++) step("miss_hold", 2'b00);
    step("miss_10", 2'b10);
    step("miss_stop", 2'b11);

    // reset mid-burst
    step("rb_rqst", 2'b01);
    step("rb_prpr", 2'b00);
    step("rb_hs", 2'b00);
    step("rb_clk", 2'b10);
    rst = 1'b1;
    step("rb_reset", 2'b01);
    step("rb_reset_hold", 2'b10);
    rst = 1'b0;
    step("rb_after", 2'b10);
    step("rb_idle", 2'b11);

    // random line states against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] ls;
      r = $urandom_range(0, 9);
      if (r < 2) ls = 2'b11;
      else if (r < 4) ls = 2'b01;
      else if (r < 8) ls = 2'b00;
      else ls = 2'b10;
      rst = ($urandom_range(0, 59) == 0);
      step("rand", ls);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
